// File: rtl/fxp_div_seq.sv
// Signed fixed-point restoring divider, q = a / b, one quotient bit per enabled cycle.
// Latency: done after start edge + dataWidth+fracWidth+1 edges (+1 with rounding); b==0 after +1 edge.
// Backpressure: start accepted only in IDLE with ce=1; start while busy is dropped; ce=0 stalls.
//
// Ports: clk, rst (async, active-high), ce, start, a/b (signed Q operands) in;
//        busy, done (1-cycle pulse), q (saturated signed Q), ovf, dz out.
// Optional macro FXP_DIV_ROUND_EN: one extra guard-bit iteration, magnitude rounded half away from zero.
module fxp_div_seq #(
    parameter int dataWidth = 16,
    parameter int fracWidth = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 start,
    input  logic [dataWidth-1:0] a,
    input  logic [dataWidth-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [dataWidth-1:0] q,
    output logic                 ovf,
    output logic                 dz
);

`ifdef FXP_DIV_ROUND_EN
    localparam int NQ = dataWidth + fracWidth + 1;
`else
    localparam int NQ = dataWidth + fracWidth;
`endif
    localparam int CW = $clog2(NQ + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [dataWidth-1:0] Q_MAX = {1'b0, {(dataWidth-1){1'b1}}};
    localparam logic [dataWidth-1:0] Q_MIN = {1'b1, {(dataWidth-1){1'b0}}};
    // Largest magnitudes representable for positive / negative results.
    localparam logic [NQ-1:0] POS_LIM = {{(NQ-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
    localparam logic [NQ-1:0] NEG_LIM = {{(NQ-dataWidth){1'b0}}, 1'b1, {(dataWidth-1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NQ-1:0]        dvd_q, dvd_d;    // dividend bits still to be shifted in, MSB first
    logic [dataWidth-1:0] rem_q, rem_d;    // partial remainder, always < |b|
    logic [NQ-1:0]        quo_q, quo_d;
    logic [dataWidth-1:0] div_q, div_d;    // |b|
    logic                 sign_q, sign_d;
    logic                 aneg_q, aneg_d;
    logic                 bz_q, bz_d;
    logic [dataWidth-1:0] q_q, q_d;
    logic                 ovf_q, ovf_d;
    logic                 dz_q, dz_d;
    logic                 done_q, done_d;

    logic [dataWidth-1:0] a_mag, b_mag;
    logic [dataWidth:0]   rem_shift, trial;
    logic                 borrow;
    logic [NQ-1:0]        qm;

    // |0x8000| wraps to 0x8000, which is the correct unsigned magnitude.
    assign a_mag = a[dataWidth-1] ? -a : a;
    assign b_mag = b[dataWidth-1] ? -b : b;

    assign rem_shift = {rem_q, dvd_q[NQ-1]};
    assign trial     = rem_shift - {1'b0, div_q};
    // Since rem_shift < 2*|b|, the top bit of the difference is exactly the borrow.
    assign borrow    = trial[dataWidth];

`ifdef FXP_DIV_ROUND_EN
    // (x + 1) >> 1 written as (x >> 1) + x[0] so no carry bit is discarded.
    assign qm = {1'b0, quo_q[NQ-1:1]} + {{(NQ-1){1'b0}}, quo_q[0]};
`else
    assign qm = quo_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        sign_d  = sign_q;
        aneg_d  = aneg_q;
        bz_d    = bz_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        done_d  = 1'b0;   // pulse clears on every edge, independent of ce
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sign_d  = a[dataWidth-1] ^ b[dataWidth-1];
                        aneg_d  = a[dataWidth-1];
                        div_d   = b_mag;
                        dvd_d   = {a_mag, {(NQ-dataWidth){1'b0}}};
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = CW'(NQ);
                        bz_d    = (b == '0);
                        state_d = (b == '0) ? S_FINISH : S_CALC;
                    end
                end
                S_CALC: begin
                    dvd_d = {dvd_q[NQ-2:0], 1'b0};
                    rem_d = borrow ? rem_shift[dataWidth-1:0] : trial[dataWidth-1:0];
                    quo_d = {quo_q[NQ-2:0], ~borrow};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FINISH;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (bz_q) begin
                        q_d   = aneg_q ? Q_MIN : Q_MAX;
                        ovf_d = 1'b0;
                        dz_d  = 1'b1;
                    end else begin
                        dz_d = 1'b0;
                        if (!sign_q) begin
                            ovf_d = (qm > POS_LIM);
                            q_d   = (qm > POS_LIM) ? Q_MAX : qm[dataWidth-1:0];
                        end else begin
                            // A zero magnitude negates to +0, so no special case is needed.
                            ovf_d = (qm > NEG_LIM);
                            q_d   = (qm > NEG_LIM) ? Q_MIN : -qm[dataWidth-1:0];
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            sign_q  <= 1'b0;
            aneg_q  <= 1'b0;
            bz_q    <= 1'b0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            sign_q  <= sign_d;
            aneg_q  <= aneg_d;
            bz_q    <= bz_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign q    = q_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Self-checking bench for fxp_div_seq: directed vectors, randomized operands against an
// arithmetic reference, clock-enable stall, ignored overlapping start, async reset mid-operation.
module tb_fxp_div_seq;

    localparam int DW = 16;
    localparam int FW = 14;
`ifdef FXP_DIV_ROUND_EN
    localparam int LAT = DW + FW + 2;
`else
    localparam int LAT = DW + FW + 1;
`endif
    localparam logic [DW-1:0] MAXV = 16'h7FFF;
    localparam logic [DW-1:0] MINV = 16'h8000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          busy, done, ovf, dz;
    logic [DW-1:0] q;

    int checks = 0;
    int errors = 0;

    fxp_div_seq #(.dataWidth(DW), .fracWidth(FW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    // Reference: exact integer quotient of magnitudes, then sign and saturation.
    function automatic void ref_div(input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                                    output logic [DW-1:0] mq, output logic mo, output logic md);
        longint am, bm, qm;
        logic   neg;
        am = longint'(ia);
        bm = longint'(ib);
        if (ia[DW-1]) am = (longint'(1) << DW) - am;
        if (ib[DW-1]) bm = (longint'(1) << DW) - bm;
        neg = ia[DW-1] ^ ib[DW-1];
        if (ib == '0) begin
            mq = ia[DW-1] ? MINV : MAXV;
            mo = 1'b0;
            md = 1'b1;
        end else begin
`ifdef FXP_DIV_ROUND_EN
            qm = (((am << (FW + 1)) / bm) + 1) >> 1;
`else
            qm = (am << FW) / bm;
`endif
            md = 1'b0;
            if (!neg) begin
                mo = (qm > (longint'(1) << (DW - 1)) - 1);
                mq = mo ? MAXV : DW'(qm);
            end else begin
                mo = (qm > (longint'(1) << (DW - 1)));
                mq = mo ? MINV : DW'(-qm);
            end
        end
    endfunction

    // Drives one operation and reports what the DUT produced. stall_len=0 / overlap_at<0 disable those.
    task automatic run_op(input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                          input int stall_at, input int stall_len, input int overlap_at,
                          output logic [DW-1:0] rq, output logic rovf, output logic rdz,
                          output int lat, output int bcnt, output int extra_done,
                          output logic [DW-1:0] rq_hold);
        @(negedge clk);
        ce = 1'b1; a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            ce    = (stall_len > 0 && lat + 1 >= stall_at && lat + 1 < stall_at + stall_len) ? 1'b0 : 1'b1;
            start = (lat + 1 == overlap_at) ? 1'b1 : 1'b0;
            a     = DW'($urandom);
            b     = DW'($urandom);
            @(posedge clk); #1;
            lat++;
            if (!done && busy) bcnt++;
        end
        rq = q; rovf = ovf; rdz = dz;
        extra_done = 0;
        @(negedge clk);
        ce = 1'b1; start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        rq_hold = q;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (q !== '0) begin errors++; $display("FAIL reset_q got %h want 0000", q); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", dz); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [DW-1:0] va [7] = '{16'h2000, 16'h4000, 16'h4000, 16'hC000, 16'h0000, 16'h4000, 16'hC000};
        logic [DW-1:0] vb [7] = '{16'h4000, 16'hE000, 16'h1000, 16'h0000, 16'h0000, 16'h6000, 16'h6000};
`ifdef FXP_DIV_ROUND_EN
        logic [DW-1:0] eq [7] = '{16'h2000, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h2AAB, 16'hD555};
`else
        logic [DW-1:0] eq [7] = '{16'h2000, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h2AAA, 16'hD556};
`endif
        logic          eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic          ed [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] rq, rqh;
        logic          ro, rd;
        int            lat, bc, xd, elat;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], 0, 0, -1, rq, ro, rd, lat, bc, xd, rqh);
            elat = (vb[i] == '0) ? 1 : LAT;
            checks++; if (rq !== eq[i]) begin errors++; $display("FAIL dir%0d_q got %h want %h", i, rq, eq[i]); end
            checks++; if (ro !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got %b want %b", i, ro, eo[i]); end
            checks++; if (rd !== ed[i]) begin errors++; $display("FAIL dir%0d_dz got %b want %b", i, rd, ed[i]); end
            checks++; if (lat != elat) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat); end
            checks++; if (bc != elat) begin errors++; $display("FAIL dir%0d_busy_edges got %0d want %0d", i, bc, elat); end
            checks++; if (xd != 0) begin errors++; $display("FAIL dir%0d_done_pulse extra %0d want 0", i, xd); end
            checks++; if (rqh !== eq[i]) begin errors++; $display("FAIL dir%0d_q_hold got %h want %h", i, rqh, eq[i]); end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ia, ib, rq, rqh, mq;
        logic          ro, rd, mo, md;
        int            lat, bc, xd, elat, sel;
        for (int i = 0; i < 30; i++) begin
            ia  = DW'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       ib = '0;
                1:       ib = DW'($urandom_range(1, 255));
                2:       ib = 16'h8000;
                3:       begin ia = 16'h8000; ib = DW'($urandom); end
                default: ib = DW'($urandom);
            endcase
            ref_div(ia, ib, mq, mo, md);
            run_op(ia, ib, 0, 0, -1, rq, ro, rd, lat, bc, xd, rqh);
            elat = (ib == '0) ? 1 : LAT;
            checks++; if (rq !== mq) begin errors++; $display("FAIL rnd_q a=%h b=%h got %h want %h", ia, ib, rq, mq); end
            checks++; if (ro !== mo) begin errors++; $display("FAIL rnd_ovf a=%h b=%h got %b want %b", ia, ib, ro, mo); end
            checks++; if (rd !== md) begin errors++; $display("FAIL rnd_dz a=%h b=%h got %b want %b", ia, ib, rd, md); end
            checks++; if (lat != elat) begin errors++; $display("FAIL rnd_latency a=%h b=%h got %0d want %0d", ia, ib, lat, elat); end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] rq, rqh, mq;
        logic          ro, rd, mo, md;
        int            lat, bc, xd;
        ref_div(16'h4000, 16'h6000, mq, mo, md);
        run_op(16'h4000, 16'h6000, 10, 5, -1, rq, ro, rd, lat, bc, xd, rqh);
        checks++; if (lat != LAT + 5) begin errors++; $display("FAIL stall_latency got %0d want %0d", lat, LAT + 5); end
        checks++; if (rq !== mq) begin errors++; $display("FAIL stall_q got %h want %h", rq, mq); end
        checks++; if (ro !== mo) begin errors++; $display("FAIL stall_ovf got %b want %b", ro, mo); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rq, rqh, mq;
        logic          ro, rd, mo, md;
        int            lat, bc, xd;
        ref_div(16'h2000, 16'hA000, mq, mo, md);
        run_op(16'h2000, 16'hA000, 0, 0, 10, rq, ro, rd, lat, bc, xd, rqh);
        checks++; if (rq !== mq) begin errors++; $display("FAIL overlap_q got %h want %h", rq, mq); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL overlap_latency got %0d want %0d", lat, LAT); end
        checks++; if (xd != 0) begin errors++; $display("FAIL overlap_single_done extra %0d want 0", xd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overlap_idle busy %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] rq, rqh, mq;
        logic          ro, rd, mo, md;
        int            lat, bc, xd;
        // Leave q/ovf nonzero so the reset has something visible to clear.
        run_op(16'h4000, 16'h1000, 0, 0, -1, rq, ro, rd, lat, bc, xd, rqh);
        @(negedge clk);
        a = 16'h4000; b = 16'h6000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %b want 1", busy); end
        #1 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got %b want 0", done); end
        checks++; if (q !== '0) begin errors++; $display("FAIL arst_q got %h want 0000", q); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf got %b want 0", ovf); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL arst_dz got %b want 0", dz); end
        @(negedge clk);
        rst = 1'b0;
        ref_div(16'hC000, 16'h6000, mq, mo, md);
        run_op(16'hC000, 16'h6000, 0, 0, -1, rq, ro, rd, lat, bc, xd, rqh);
        checks++; if (rq !== mq) begin errors++; $display("FAIL arst_after_q got %h want %h", rq, mq); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL arst_after_latency got %0d want %0d", lat, LAT); end
        checks++; if (ro !== mo) begin errors++; $display("FAIL arst_after_ovf got %b want %b", ro, mo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
